// File: rtl/ro_gate_timer_pkg.sv
// Shared types and constants for the RO PUF measurement-window timer.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } gate_state_t;

    // Default gate length in clk cycles when the limit input is 0.
    localparam int unsigned DEFAULT_WINDOW = 60000000;

endpackage

// File: rtl/ro_gate_timer_if.sv
// Control/status bundle between a PUF controller (master) and the gate timer (slave).
interface ro_gate_timer_if
    import puf_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             abort;
    logic             cont_mode;
    logic [CNT_W-1:0] limit;
    logic             gate;
    logic [CNT_W-1:0] cnt;
    logic             cnt_max;
    logic             done;
    logic             busy;
    gate_state_t      state;

    // start/abort are level-sampled on each clk edge; done is a single-cycle
    // pulse and there is no ready back-pressure: the timer is always able to
    // take a request, it simply ignores start unless it is idle.
    modport master (
        output start, abort, cont_mode, limit,
        input  gate, cnt, cnt_max, done, busy, state
    );

    modport slave (
        input  start, abort, cont_mode, limit,
        output gate, cnt, cnt_max, done, busy, state
    );
endinterface

// File: rtl/ro_gate_timer.sv
// Measurement-window generator: gates the RO counters for limit_q cycles,
// waits SETTLE_CYC cycles for their synchronisers, then pulses done.
module ro_gate_timer
    import puf_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned DEFAULT_LIMIT = DEFAULT_WINDOW,
    parameter int unsigned SETTLE_CYC    = 4
) (
    input logic            clk,
    input logic            rst,
    ro_gate_timer_if.slave bus
);

    localparam int unsigned SW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] DEF_L       = CNT_W'(DEFAULT_LIMIT);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam gate_state_t      AFTER_RUN   = (SETTLE_CYC > 0) ? SETTLE : DONE;

    if (64'(DEFAULT_LIMIT) >= (64'd1 << CNT_W)) begin : g_limit_check
        $error("DEFAULT_LIMIT does not fit in CNT_W bits");
    end

    gate_state_t      state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             gate_q, gate_d;
    logic             cnt_max_q, cnt_max_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] limit_eff;

    assign limit_eff = (bus.limit == '0) ? DEF_L : bus.limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            cnt_q     <= '0;
            limit_q   <= '0;
            gate_q    <= 1'b0;
            cnt_max_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            cnt_q     <= cnt_d;
            limit_q   <= limit_d;
            gate_q    <= gate_d;
            cnt_max_q <= cnt_max_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        limit_d   = limit_q;
        gate_d    = gate_q;
        cnt_max_d = cnt_max_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    limit_d   = limit_eff;
                    cnt_d     = '0;
                    gate_d    = 1'b1;
                    cnt_max_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // limit_q is never 0 here, so the terminal compare cannot underflow.
                if (cnt_q == limit_q - CNT_W'(1)) begin
                    cnt_d     = limit_q;
                    gate_d    = 1'b0;
                    cnt_max_d = 1'b1;
                    settle_d  = '0;
                    state_d   = AFTER_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = DONE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            DONE: begin
                if (bus.cont_mode) begin
                    limit_d   = limit_eff;
                    cnt_d     = '0;
                    cnt_max_d = 1'b0;
                    gate_d    = 1'b1;
                    state_d   = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort) begin
            state_d   = IDLE;
            settle_d  = '0;
            cnt_d     = '0;
            gate_d    = 1'b0;
            cnt_max_d = 1'b0;
        end

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    assign bus.gate    = gate_q;
    assign bus.cnt     = cnt_q;
    assign bus.cnt_max = cnt_max_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_ro_gate_timer.sv
// Bench for ro_gate_timer: two builds (SETTLE_CYC=2 and 0) driven in lockstep
// and compared each cycle against a window-position reference model.
module tb_ro_gate_timer;
    import puf_pkg::*;

    localparam int CNT_W = 8;
    localparam int DEF   = 10;
    localparam int S0    = 2;
    localparam int S1    = 0;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             start     = 1'b0;
    logic             abort     = 1'b0;
    logic             cont_mode = 1'b0;
    logic [CNT_W-1:0] limit     = '0;

    ro_gate_timer_if #(.CNT_W(CNT_W)) bus0 ();
    ro_gate_timer_if #(.CNT_W(CNT_W)) bus1 ();

    assign bus0.start = start;     assign bus1.start = start;
    assign bus0.abort = abort;     assign bus1.abort = abort;
    assign bus0.cont_mode = cont_mode; assign bus1.cont_mode = cont_mode;
    assign bus0.limit = limit;     assign bus1.limit = limit;

    ro_gate_timer #(.CNT_W(CNT_W), .DEFAULT_LIMIT(DEF), .SETTLE_CYC(S0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    ro_gate_timer #(.CNT_W(CNT_W), .DEFAULT_LIMIT(DEF), .SETTLE_CYC(S1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // reference model: a window is described by its position t (edges since
    // the start edge) and its length lim; outputs follow from plain arithmetic
    int m_active[2];
    int m_t[2];
    int m_lim[2];
    int m_cnt[2];
    int m_cmax[2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    task automatic model_reset(input int i);
        m_active[i] = 0; m_t[i] = 0; m_lim[i] = 0; m_cnt[i] = 0; m_cmax[i] = 0;
    endtask

    task automatic model_step(input int i);
        int s;
        s = settle_of(i);
        if (rst || abort) begin
            model_reset(i);
        end else if (m_active[i] == 0) begin
            if (start) begin
                m_active[i] = 1;
                m_t[i]      = 0;
                m_lim[i]    = (limit == 0) ? DEF : int'(limit);
            end
        end else begin
            m_t[i]++;
            if (m_t[i] == m_lim[i] + s + 1) begin
                if (cont_mode) begin
                    m_t[i]   = 0;
                    m_lim[i] = (limit == 0) ? DEF : int'(limit);
                end else begin
                    m_active[i] = 0;
                    m_cnt[i]    = m_lim[i];
                    m_cmax[i]   = 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        int t, lim, s;
        int e_gate, e_cnt, e_cmax, e_done, e_busy;
        logic       g_gate, g_cmax, g_done, g_busy;
        logic [7:0] g_cnt;
        for (int i = 0; i < 2; i++) begin
            t = m_t[i]; lim = m_lim[i]; s = settle_of(i);
            if (m_active[i] != 0) begin
                e_gate = (t < lim) ? 1 : 0;
                e_cnt  = (t < lim) ? t : lim;
                e_cmax = (t >= lim) ? 1 : 0;
                e_done = (t == lim + s) ? 1 : 0;
                e_busy = 1;
            end else begin
                e_gate = 0; e_cnt = m_cnt[i]; e_cmax = m_cmax[i]; e_done = 0; e_busy = 0;
            end
            g_gate = (i == 0) ? bus0.gate    : bus1.gate;
            g_cnt  = (i == 0) ? bus0.cnt     : bus1.cnt;
            g_cmax = (i == 0) ? bus0.cnt_max : bus1.cnt_max;
            g_done = (i == 0) ? bus0.done    : bus1.done;
            g_busy = (i == 0) ? bus0.busy    : bus1.busy;
            check($sformatf("%s/s%0d.gate", tag, s),    32'(g_gate), 32'(e_gate));
            check($sformatf("%s/s%0d.cnt", tag, s),     32'(g_cnt),  32'(e_cnt));
            check($sformatf("%s/s%0d.cnt_max", tag, s), 32'(g_cmax), 32'(e_cmax));
            check($sformatf("%s/s%0d.done", tag, s),    32'(g_done), 32'(e_done));
            check($sformatf("%s/s%0d.busy", tag, s),    32'(g_busy), 32'(e_busy));
        end
    endtask

    // driver tasks: inputs only change 1 time unit after a rising edge
    task automatic step_cycle(input string tag);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) step_cycle(tag);
    endtask

    task automatic pulse_start(input int lim, input string tag);
        limit = CNT_W'(lim);
        start = 1'b1;
        step_cycle(tag);
        start = 1'b0;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);

        run(2, "reset");
        rst = 1'b0;
        run(2, "idle");

        // single shot, limit 5
        pulse_start(5, "single");
        run(12, "single");

        // default limit through limit=0
        pulse_start(0, "default");
        run(16, "default");

        // continuous, limit change mid-window applies to the next window only
        cont_mode = 1'b1;
        pulse_start(3, "cont");
        run(2, "cont");
        limit = 8'd4;
        run(20, "cont");
        cont_mode = 1'b0;
        run(10, "cont_end");

        // abort together with start in IDLE, then abort in RUN at cnt=2
        abort = 1'b1; start = 1'b1; limit = 8'd6;
        step_cycle("abort_idle");
        abort = 1'b0; start = 1'b0;
        run(2, "abort_idle");
        pulse_start(6, "abort_run");
        run(2, "abort_run");
        abort = 1'b1;
        step_cycle("abort_run");
        abort = 1'b0;
        run(4, "abort_run");

        // start held high through RUN and SETTLE
        limit = 8'd4; start = 1'b1;
        run(8, "busy_start");
        start = 1'b0;
        run(10, "busy_start");

        // asynchronous reset while dut0 is settling
        pulse_start(3, "rst_mid");
        run(4, "rst_mid");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.gate0", 32'(bus0.gate), 32'd0);
        check("async_rst.cnt0",  32'(bus0.cnt),  32'd0);
        check("async_rst.busy0", 32'(bus0.busy), 32'd0);
        check("async_rst.done0", 32'(bus0.done), 32'd0);
        check("async_rst.gate1", 32'(bus1.gate), 32'd0);
        check("async_rst.busy1", 32'(bus1.busy), 32'd0);
        model_reset(0);
        model_reset(1);
        step_cycle("rst_hold");
        rst = 1'b0;
        pulse_start(2, "after_rst");
        run(8, "after_rst");

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            if ((k % 60) == 0) cont_mode = $urandom_range(0, 1) == 1;
            limit = CNT_W'($urandom_range(0, 7));
            step_cycle("random");
        end
        start = 1'b0; abort = 1'b0; cont_mode = 1'b0;
        run(20, "drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
